// File: rtl/undo_stack_ctrl.sv
// Undo-buffer controller: arbitrates push/pop/clear onto a single-port synchronous RAM
// and keeps circular LIFO bookkeeping (overwrite-oldest on full, error on empty pop).
module undo_stack_ctrl #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_req,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ack,
   output logic             dropped,
   input  logic             pop_req,
   output logic             pop_ack,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_err,
   input  logic             clear_req,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH    = 3'd1,
      POP_RD  = 3'd2,
      POP_WT  = 3'd3,
      POP_RSP = 3'd4,
      POP_ERR = 3'd5
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t           r_state;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_count;
   logic             r_empty;
   logic             r_full;
   logic             r_push_ack;
   logic             r_dropped;
   logic             r_pop_ack;
   logic             r_pop_err;
   logic [WIDTH-1:0] r_pop_data;
   logic             r_mem_we;
   logic [AW-1:0]    r_mem_addr;
   logic [WIDTH-1:0] r_mem_wdata;

   logic [AW-1:0]    w_ptr_inc;
   logic [AW-1:0]    w_ptr_dec;
   logic [AW:0]      w_count_inc;
   logic [AW:0]      w_count_dec;

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   assign w_ptr_inc   = r_wr_ptr + 1'b1;
   assign w_ptr_dec   = r_wr_ptr - 1'b1;
   assign w_count_inc = r_count + 1'b1;
   assign w_count_dec = r_count - 1'b1;

   // All outputs are registered: they are set on the edge that enters the state
   // they belong to, and cleared by default on every other edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_push_ack  <= 1'b0;
         r_dropped   <= 1'b0;
         r_pop_ack   <= 1'b0;
         r_pop_err   <= 1'b0;
         r_pop_data  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_push_ack  <= 1'b0;
         r_dropped   <= 1'b0;
         r_pop_ack   <= 1'b0;
         r_pop_err   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         case (r_state)
            IDLE: begin
               if (clear_req) begin
                  r_count <= '0;
                  r_empty <= 1'b1;
                  r_full  <= 1'b0;
               end else if (push_req) begin
                  r_state     <= PUSH;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_wr_ptr;
                  r_mem_wdata <= push_data;
                  r_push_ack  <= 1'b1;
                  r_dropped   <= r_full;
               end else if (pop_req) begin
                  if (r_empty) begin
                     r_state    <= POP_ERR;
                     r_pop_ack  <= 1'b1;
                     r_pop_err  <= 1'b1;
                     r_pop_data <= '0;
                  end else begin
                     r_state    <= POP_RD;
                     r_mem_addr <= w_ptr_dec;
                  end
               end
            end
            PUSH: begin
               r_wr_ptr <= w_ptr_inc;
               if (!r_full) begin
                  r_count <= w_count_inc;
                  r_full  <= (w_count_inc == FULL_CNT);
               end
               r_empty <= 1'b0;
               r_state <= IDLE;
            end
            POP_RD: begin
               r_state <= POP_WT;
            end
            POP_WT: begin
               // RAM data addressed in POP_RD is valid during this cycle.
               r_pop_data <= mem_rdata;
               r_pop_ack  <= 1'b1;
               r_state    <= POP_RSP;
            end
            POP_RSP: begin
               r_wr_ptr <= w_ptr_dec;
               r_count  <= w_count_dec;
               r_empty  <= (w_count_dec == '0);
               r_full   <= 1'b0;
               r_state  <= IDLE;
            end
            POP_ERR: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign push_ack  = r_push_ack;
   assign dropped   = r_dropped;
   assign pop_ack   = r_pop_ack;
   assign pop_err   = r_pop_err;
   assign pop_data  = r_pop_data;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign count     = r_count;
   assign empty     = r_empty;
   assign full      = r_full;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_undo_stack_ctrl.sv
// Bench for undo_stack_ctrl: directed scenarios plus a random push/pop/clear run
// checked against a queue model of the circular undo stack.
module tb_undo_stack_ctrl;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clk;
   logic             reset;
   logic             push_req;
   logic [WIDTH-1:0] push_data;
   logic             push_ack;
   logic             dropped;
   logic             pop_req;
   logic             pop_ack;
   logic [WIDTH-1:0] pop_data;
   logic             pop_err;
   logic             clear_req;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic [2:0]       dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] ram[DEPTH];

   undo_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .push_req(push_req), .push_data(push_data), .push_ack(push_ack), .dropped(dropped),
      .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data), .pop_err(pop_err),
      .clear_req(clear_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .count(count), .empty(empty), .full(full), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port synchronous RAM model
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = '0;
      mem_rdata = '0;
   end
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // model: circular LIFO that discards the oldest entry when full
   function automatic logic model_push(input logic [WIDTH-1:0] d);
      logic drop;
      drop = (model_q.size() == DEPTH);
      if (drop) void'(model_q.pop_front());
      model_q.push_back(d);
      return drop;
   endfunction

   // driver tasks: start and end on a negedge, return once the controller is back in IDLE
   task automatic do_push(input logic [WIDTH-1:0] d, output logic drop, output logic ok);
      ok = 1'b0;
      drop = 1'b0;
      push_req = 1'b1;
      push_data = d;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (push_ack) begin
            ok = 1'b1;
            drop = dropped;
            break;
         end
      end
      push_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_pop(output logic [WIDTH-1:0] d, output logic err, output logic ok);
      ok = 1'b0;
      d = '0;
      err = 1'b0;
      pop_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (pop_ack) begin
            ok = 1'b1;
            d = pop_data;
            err = pop_err;
            break;
         end
      end
      pop_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      push_req = 1'b0;
      pop_req = 1'b0;
      clear_req = 1'b0;
      push_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      model_q.delete();
   endtask

   task automatic test_reset();
      logic [2*WIDTH+AW+AW+7:0] got, exp;
      apply_reset();
      got = {push_ack, dropped, pop_ack, pop_err, pop_data, mem_we, mem_addr, mem_wdata, count, empty, full};
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 5'd0, 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL reset_outputs got=%h want=%h", got, exp);
      end
   endtask

   task automatic test_push_pop_order();
      logic drop, ok, err;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] vals[2];
      logic [WIDTH-1:0] want;
      vals[0] = 16'h1234;
      vals[1] = 16'hBEEF;
      for (int i = 0; i < 2; i++) begin
         do_push(vals[i], drop, ok);
         void'(model_push(vals[i]));
         n_cmp++;
         if (!ok || drop !== 1'b0 || count !== 5'(i + 1)) begin
            n_err++;
            $display("FAIL push_order ok=%0b drop=%0b count=%0d want count=%0d", ok, drop, count, i + 1);
         end
      end
      for (int i = 0; i < 2; i++) begin
         do_pop(d, err, ok);
         want = model_q.pop_back();
         n_cmp++;
         if (!ok || err !== 1'b0 || d !== want || count !== 5'(1 - i)) begin
            n_err++;
            $display("FAIL pop_order ok=%0b err=%0b data=%h want=%h count=%0d want=%0d", ok, err, d, want, count, 1 - i);
         end
      end
      n_cmp++;
      if (empty !== 1'b1) begin
         n_err++;
         $display("FAIL pop_order_empty got=%0b want=1", empty);
      end
   endtask

   task automatic test_pop_empty();
      logic seen_ack, bad;
      logic [WIDTH-1:0] d;
      logic e;
      seen_ack = 1'b0;
      bad = 1'b0;
      d = '1;
      e = 1'b0;
      pop_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (mem_we !== 1'b0 || count !== 5'd0) bad = 1'b1;
         if (pop_ack) begin
            seen_ack = 1'b1;
            d = pop_data;
            e = pop_err;
            break;
         end
      end
      pop_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (!seen_ack || e !== 1'b1 || d !== 16'h0000 || bad) begin
         n_err++;
         $display("FAIL pop_empty ack=%0b err=%0b data=%h side_effect=%0b want ack=1 err=1 data=0000 side_effect=0", seen_ack, e, d, bad);
      end
   endtask

   task automatic test_overwrite();
      logic drop, ok, err, want_drop;
      logic [WIDTH-1:0] d, want;
      int bad_drop;
      bad_drop = 0;
      for (int i = 0; i < 17; i++) begin
         d = (i == 16) ? 16'h00AA : 16'(i);
         do_push(d, drop, ok);
         want_drop = model_push(d);
         if (!ok || drop !== want_drop) bad_drop++;
      end
      n_cmp++;
      if (bad_drop != 0 || count !== 5'd16 || full !== 1'b1) begin
         n_err++;
         $display("FAIL overwrite_push bad_drops=%0d count=%0d full=%0b want 0 16 1", bad_drop, count, full);
      end
      for (int i = 0; i < 16; i++) begin
         do_pop(d, err, ok);
         want = model_q.pop_back();
         n_cmp++;
         if (!ok || err !== 1'b0 || d !== want) begin
            n_err++;
            $display("FAIL overwrite_pop%0d ok=%0b err=%0b data=%h want=%h", i, ok, err, d, want);
         end
      end
      do_pop(d, err, ok);
      n_cmp++;
      if (!ok || err !== 1'b1 || d !== 16'h0 || empty !== 1'b1) begin
         n_err++;
         $display("FAIL overwrite_pop17 ok=%0b err=%0b data=%h empty=%0b want err=1 data=0 empty=1", ok, err, d, empty);
      end
   endtask

   task automatic test_back_to_back();
      int push_at, pop_at;
      logic [WIDTH-1:0] d;
      logic e;
      push_at = -1;
      pop_at = -1;
      d = '0;
      e = 1'b1;
      push_req = 1'b1;
      push_data = 16'h5555;
      pop_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (push_ack) begin
            push_at = i;
            push_req = 1'b0;
         end
         if (pop_ack) begin
            pop_at = i;
            d = pop_data;
            e = pop_err;
            pop_req = 1'b0;
            break;
         end
      end
      push_req = 1'b0;
      pop_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (push_at != 0 || pop_at <= push_at || d !== 16'h5555 || e !== 1'b0) begin
         n_err++;
         $display("FAIL back_to_back push_at=%0d pop_at=%0d data=%h err=%0b want push_at=0 pop later data=5555 err=0", push_at, pop_at, d, e);
      end
      n_cmp++;
      if (count !== 5'd0) begin
         n_err++;
         $display("FAIL back_to_back_count got=%0d want=0", count);
      end
   endtask

   task automatic test_reset_mid_pop();
      logic drop, ok, err;
      logic [WIDTH-1:0] d;
      logic ack_seen;
      for (int i = 0; i < 3; i++) begin
         do_push(16'h0100 + 16'(i), drop, ok);
         void'(model_push(16'h0100 + 16'(i)));
      end
      pop_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      // edge 1 entered the RAM read, edge 2 entered the wait cycle
      reset = 1'b0;
      pop_req = 1'b0;
      model_q.delete();
      #1;
      n_cmp++;
      if (pop_ack !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_pop ack=%0b count=%0d empty=%0b want 0 0 1", pop_ack, count, empty);
      end
      @(negedge clk);
      reset = 1'b1;
      ack_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (pop_ack) ack_seen = 1'b1;
      end
      n_cmp++;
      if (ack_seen) begin
         n_err++;
         $display("FAIL reset_mid_pop_no_ack got ack=1 want 0");
      end
      do_pop(d, err, ok);
      n_cmp++;
      if (!ok || err !== 1'b1 || d !== 16'h0) begin
         n_err++;
         $display("FAIL reset_mid_pop_after ok=%0b err=%0b data=%h want err=1 data=0", ok, err, d);
      end
   endtask

   task automatic test_clear_vs_push();
      logic drop, ok, err;
      logic [WIDTH-1:0] d, want;
      logic got_ack;
      for (int i = 0; i < 3; i++) begin
         do_push(16'h0A00 + 16'(i), drop, ok);
         void'(model_push(16'h0A00 + 16'(i)));
      end
      clear_req = 1'b1;
      push_req = 1'b1;
      push_data = 16'h7777;
      @(negedge clk);
      n_cmp++;
      if (empty !== 1'b1 || count !== 5'd0 || push_ack !== 1'b0) begin
         n_err++;
         $display("FAIL clear_wins empty=%0b count=%0d push_ack=%0b want 1 0 0", empty, count, push_ack);
      end
      clear_req = 1'b0;
      model_q.delete();
      got_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (push_ack) begin
            got_ack = 1'b1;
            break;
         end
      end
      push_req = 1'b0;
      void'(model_push(16'h7777));
      @(negedge clk);
      n_cmp++;
      if (!got_ack || count !== 5'd1) begin
         n_err++;
         $display("FAIL clear_then_push ack=%0b count=%0d want ack=1 count=1", got_ack, count);
      end
      do_pop(d, err, ok);
      want = model_q.pop_back();
      n_cmp++;
      if (!ok || err !== 1'b0 || d !== want) begin
         n_err++;
         $display("FAIL clear_then_pop ok=%0b err=%0b data=%h want=%h", ok, err, d, want);
      end
   endtask

   task automatic test_random();
      logic drop, ok, err, want_drop, want_err;
      logic [WIDTH-1:0] d, want;
      int op;
      for (int n = 0; n < 250; n++) begin
         op = $urandom_range(0, 19);
         if (op < 10) begin
            d = 16'($urandom);
            do_push(d, drop, ok);
            want_drop = model_push(d);
            n_cmp++;
            if (!ok || drop !== want_drop) begin
               n_err++;
               $display("FAIL rand_push op%0d ok=%0b dropped=%0b want=%0b", n, ok, drop, want_drop);
            end
         end else if (op < 19) begin
            do_pop(d, err, ok);
            want_err = (model_q.size() == 0);
            want = want_err ? '0 : model_q.pop_back();
            n_cmp++;
            if (!ok || err !== want_err || d !== want) begin
               n_err++;
               $display("FAIL rand_pop op%0d ok=%0b err=%0b data=%h want err=%0b data=%h", n, ok, err, d, want_err, want);
            end
         end else begin
            clear_req = 1'b1;
            @(negedge clk);
            clear_req = 1'b0;
            model_q.delete();
            @(negedge clk);
         end
         n_cmp++;
         if (count !== 5'(model_q.size()) || empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin
            n_err++;
            $display("FAIL rand_flags op%0d count=%0d empty=%0b full=%0b want count=%0d", n, count, empty, full, model_q.size());
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      push_req = 1'b0;
      pop_req = 1'b0;
      clear_req = 1'b0;
      push_data = '0;
      @(negedge clk);
      test_reset();
      test_push_pop_order();
      test_pop_empty();
      test_overwrite();
      test_back_to_back();
      test_reset_mid_pop();
      test_clear_vs_push();
      apply_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
